// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result slots, load-return handshake and the two
// register-file write ports. master = pipeline/testbench side, slave = arbiter.
interface wb_arbiter_if #(
  parameter int LQ_DEPTH = 4
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic          en;
  logic          alu0_valid;
  logic [4:0]    alu0_rd;
  logic [31:0]   alu0_data;
  logic          alu1_valid;
  logic [4:0]    alu1_rd;
  logic [31:0]   alu1_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_data;
  logic          reg_write;
  logic [4:0]    regd;
  logic [31:0]   write_data;
  logic          reg_write2;
  logic [4:0]    regd2;
  logic [31:0]   write_data2;
  logic [31:0]   pending_mask;
  logic [CW-1:0] lq_count;

  modport master (
    output en, alu0_valid, alu0_rd, alu0_data, alu1_valid, alu1_rd, alu1_data,
           ld_valid, ld_rd, ld_data,
    input  ld_ready, reg_write, regd, write_data, reg_write2, regd2, write_data2,
           pending_mask, lq_count
  );

  modport slave (
    input  en, alu0_valid, alu0_rd, alu0_data, alu1_valid, alu1_rd, alu1_data,
           ld_valid, ld_rd, ld_data,
    output ld_ready, reg_write, regd, write_data, reg_write2, regd2, write_data2,
           pending_mask, lq_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results pass straight to the two write ports, queued
// load returns fill idle ports. Optional same-cycle load bypass: WB_BYPASS_EN.
module wb_arbiter #(
  parameter int LQ_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    q_rd_r   [LQ_DEPTH];
  logic [31:0]   q_data_r [LQ_DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          reg_write_r, reg_write2_r;
  logic [4:0]    regd_r, regd2_r;
  logic [31:0]   write_data_r, write_data2_r;
  logic          out_ld1_r, out_ld2_r;

  logic          ld_ready_s, push_s;
  logic          take1_s, take2_s, avail2_s;
  logic [PW-1:0] sel2_s;
  logic [4:0]    rd1_s, rd2_s;
  logic [31:0]   data1_s, data2_s;
  logic          stale1_s, stale2_s;
  logic [CW-1:0] pops_s;
  logic          byp1_s, byp2_s, byp_stale_s;
  logic [31:0]   pend_s;

  // A load is stale when a valid ALU result in the same cycle targets its rd.
  function automatic logic is_stale(input logic [4:0] rd,
                                    input logic v0, input logic [4:0] rd0,
                                    input logic v1, input logic [4:0] rd1);
    is_stale = (v0 && (rd == rd0)) || (v1 && (rd == rd1));
  endfunction

  // Drain selection, stale detection, bypass and enqueue decisions.
  always_comb begin
    ld_ready_s = (count_r < CW'(LQ_DEPTH));
    take1_s    = bus.en && !bus.alu0_valid && (count_r != {CW{1'b0}});
    if (take1_s) begin
      sel2_s   = head_r + PW'(1'b1);
      avail2_s = (count_r > CW'(1'b1));
    end else begin
      sel2_s   = head_r;
      avail2_s = (count_r != {CW{1'b0}});
    end
    take2_s  = bus.en && !bus.alu1_valid && avail2_s;
    rd1_s    = q_rd_r[head_r];
    data1_s  = q_data_r[head_r];
    rd2_s    = q_rd_r[sel2_s];
    data2_s  = q_data_r[sel2_s];
    stale1_s = is_stale(rd1_s, bus.alu0_valid, bus.alu0_rd, bus.alu1_valid, bus.alu1_rd);
    stale2_s = is_stale(rd2_s, bus.alu0_valid, bus.alu0_rd, bus.alu1_valid, bus.alu1_rd);
    pops_s   = {{(CW-1){1'b0}}, take1_s} + {{(CW-1){1'b0}}, take2_s};
    byp1_s      = 1'b0;
    byp2_s      = 1'b0;
    byp_stale_s = is_stale(bus.ld_rd, bus.alu0_valid, bus.alu0_rd,
                           bus.alu1_valid, bus.alu1_rd);
`ifdef WB_BYPASS_EN
    if ((count_r == {CW{1'b0}}) && bus.en && bus.ld_valid && (bus.ld_rd != 5'd0)) begin
      if (!bus.alu0_valid) begin
        byp1_s = 1'b1;
      end else if (!bus.alu1_valid) begin
        byp2_s = 1'b1;
      end else begin
        byp1_s = 1'b0;
      end
    end else begin
      byp1_s = 1'b0;
    end
`endif
    push_s = bus.ld_valid && ld_ready_s && (bus.ld_rd != 5'd0) && !byp1_s && !byp2_s;
  end

  // Pending-load mask: live queue entries plus loads staged in the output registers.
  always_comb begin
    pend_s = 32'h0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if ({1'b0, PW'(i) - head_r} < count_r) begin
        pend_s = pend_s | (32'h1 << q_rd_r[i]);
      end else begin
        pend_s = pend_s;
      end
    end
    if (out_ld1_r) begin
      pend_s = pend_s | (32'h1 << regd_r);
    end else begin
      pend_s = pend_s;
    end
    if (out_ld2_r) begin
      pend_s = pend_s | (32'h1 << regd2_r);
    end else begin
      pend_s = pend_s;
    end
  end

  // Queue state and registered write ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r        <= {PW{1'b0}};
      tail_r        <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      reg_write_r   <= 1'b0;
      regd_r        <= 5'd0;
      write_data_r  <= 32'h0;
      reg_write2_r  <= 1'b0;
      regd2_r       <= 5'd0;
      write_data2_r <= 32'h0;
      out_ld1_r     <= 1'b0;
      out_ld2_r     <= 1'b0;
    end else begin
      if (push_s) begin
        q_rd_r[tail_r]   <= bus.ld_rd;
        q_data_r[tail_r] <= bus.ld_data;
        tail_r           <= tail_r + PW'(1'b1);
      end
      head_r  <= head_r + pops_s[PW-1:0];
      count_r <= count_r + {{(CW-1){1'b0}}, push_s} - pops_s;

      if (bus.en && bus.alu0_valid) begin
        reg_write_r  <= 1'b1;
        regd_r       <= bus.alu0_rd;
        write_data_r <= bus.alu0_data;
        out_ld1_r    <= 1'b0;
      end else if (take1_s && !stale1_s) begin
        reg_write_r  <= 1'b1;
        regd_r       <= rd1_s;
        write_data_r <= data1_s;
        out_ld1_r    <= 1'b1;
      end else if (byp1_s && !byp_stale_s) begin
        reg_write_r  <= 1'b1;
        regd_r       <= bus.ld_rd;
        write_data_r <= bus.ld_data;
        out_ld1_r    <= 1'b1;
      end else begin
        reg_write_r  <= 1'b0;
        regd_r       <= 5'd0;
        write_data_r <= 32'h0;
        out_ld1_r    <= 1'b0;
      end

      if (bus.en && bus.alu1_valid) begin
        reg_write2_r  <= 1'b1;
        regd2_r       <= bus.alu1_rd;
        write_data2_r <= bus.alu1_data;
        out_ld2_r     <= 1'b0;
      end else if (take2_s && !stale2_s) begin
        reg_write2_r  <= 1'b1;
        regd2_r       <= rd2_s;
        write_data2_r <= data2_s;
        out_ld2_r     <= 1'b1;
      end else if (byp2_s && !byp_stale_s) begin
        reg_write2_r  <= 1'b1;
        regd2_r       <= bus.ld_rd;
        write_data2_r <= bus.ld_data;
        out_ld2_r     <= 1'b1;
      end else begin
        reg_write2_r  <= 1'b0;
        regd2_r       <= 5'd0;
        write_data2_r <= 32'h0;
        out_ld2_r     <= 1'b0;
      end
    end
  end

  assign bus.ld_ready     = ld_ready_s;
  assign bus.reg_write    = reg_write_r;
  assign bus.regd         = regd_r;
  assign bus.write_data   = write_data_r;
  assign bus.reg_write2   = reg_write2_r;
  assign bus.regd2        = regd2_r;
  assign bus.write_data2  = write_data2_r;
  assign bus.pending_mask = pend_s;
  assign bus.lq_count     = count_r;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (LQ_DEPTH = 4); expectations
// switch on WB_BYPASS_EN where load latency differs.
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  wb_arbiter_if #(.LQ_DEPTH(4)) bus ();
  wb_arbiter #(.LQ_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    bus.alu0_valid = v0; bus.alu0_rd = r0; bus.alu0_data = d0;
    bus.alu1_valid = v1; bus.alu1_rd = r1; bus.alu1_data = d1;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.ld_valid = v; bus.ld_rd = r; bus.ld_data = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.en = 1'b1;
    set_alu(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_ld(1'b0, 5'd0, 32'h0);
    step(); step();
    check_eq("rst_wr1", 32'(bus.reg_write), 32'h0);
    check_eq("rst_wr2", 32'(bus.reg_write2), 32'h0);
    check_eq("rst_cnt", 32'(bus.lq_count), 32'h0);
    check_eq("rst_rdy", 32'(bus.ld_ready), 32'h1);
    rst = 1'b0;

    // reset mid-queue
    set_alu(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hB6);
    for (int k = 1; k <= 3; k++) begin
      set_ld(1'b1, 5'(k), 32'(k));
      step();
    end
    set_ld(1'b0, 5'd0, 32'h0);
    check_eq("mq_cnt", 32'(bus.lq_count), 32'h3);
    check_eq("mq_pend", bus.pending_mask, 32'h0000_000E);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mrst_cnt", 32'(bus.lq_count), 32'h0);
    check_eq("mrst_pend", bus.pending_mask, 32'h0);
    check_eq("mrst_wr1", 32'(bus.reg_write), 32'h0);
    check_eq("mrst_wr2", 32'(bus.reg_write2), 32'h0);
    check_eq("mrst_rdy", 32'(bus.ld_ready), 32'h1);

    // both ALUs busy, loads wait, then drain together
    set_alu(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hB6);
    set_ld(1'b1, 5'd7, 32'h77);
    step();
    check_eq("alu_rd1", 32'(bus.regd), 32'd5);
    check_eq("alu_d1", bus.write_data, 32'hA5);
    check_eq("alu_wr2", 32'(bus.reg_write2), 32'h1);
    check_eq("alu_rd2", 32'(bus.regd2), 32'd6);
    set_ld(1'b1, 5'd8, 32'h88);
    step();
    set_ld(1'b0, 5'd0, 32'h0);
    step(); step();
    check_eq("busy_pend", bus.pending_mask, 32'h0000_0180);
    check_eq("busy_cnt", 32'(bus.lq_count), 32'h2);
    set_alu(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check_eq("dr_wr1", 32'(bus.reg_write), 32'h1);
    check_eq("dr_rd1", 32'(bus.regd), 32'd7);
    check_eq("dr_d1", bus.write_data, 32'h77);
    check_eq("dr_wr2", 32'(bus.reg_write2), 32'h1);
    check_eq("dr_rd2", 32'(bus.regd2), 32'd8);
    check_eq("dr_d2", bus.write_data2, 32'h88);
    check_eq("dr_cnt", 32'(bus.lq_count), 32'h0);
    step();
    check_eq("dr_idle", 32'(bus.reg_write), 32'h0);
    check_eq("dr_pend0", bus.pending_mask, 32'h0);

    // stale drop
    set_alu(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hB6);
    set_ld(1'b1, 5'd9, 32'h11);
    step();
    set_ld(1'b0, 5'd0, 32'h0);
    check_eq("st_pend", bus.pending_mask, 32'h0000_0200);
    set_alu(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h22);
    step();
    check_eq("st_wr1", 32'(bus.reg_write), 32'h0);
    check_eq("st_wr2", 32'(bus.reg_write2), 32'h1);
    check_eq("st_rd2", 32'(bus.regd2), 32'd9);
    check_eq("st_d2", bus.write_data2, 32'h22);
    check_eq("st_cnt", 32'(bus.lq_count), 32'h0);
    check_eq("st_pend0", bus.pending_mask, 32'h0);

    // fill past capacity
    set_alu(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hB6);
    for (int k = 0; k < 4; k++) begin
      set_ld(1'b1, 5'(10 + k), 32'h100 + 32'(k));
      step();
    end
    check_eq("fill_cnt", 32'(bus.lq_count), 32'h4);
    check_eq("fill_rdy", 32'(bus.ld_ready), 32'h0);
    set_ld(1'b1, 5'd14, 32'h104);
    step();
    check_eq("held_cnt", 32'(bus.lq_count), 32'h4);
    check_eq("held_rdy", 32'(bus.ld_ready), 32'h0);
    set_alu(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check_eq("f1_rd1", 32'(bus.regd), 32'd10);
    check_eq("f1_d1", bus.write_data, 32'h100);
    check_eq("f1_rd2", 32'(bus.regd2), 32'd11);
    check_eq("f1_cnt", 32'(bus.lq_count), 32'h2);
    check_eq("f1_rdy", 32'(bus.ld_ready), 32'h1);
    step();
    set_ld(1'b0, 5'd0, 32'h0);
    check_eq("f2_rd1", 32'(bus.regd), 32'd12);
    check_eq("f2_rd2", 32'(bus.regd2), 32'd13);
    check_eq("f2_cnt", 32'(bus.lq_count), 32'h1);
    step();
    check_eq("f3_wr1", 32'(bus.reg_write), 32'h1);
    check_eq("f3_rd1", 32'(bus.regd), 32'd14);
    check_eq("f3_d1", bus.write_data, 32'h104);
    check_eq("f3_wr2", 32'(bus.reg_write2), 32'h0);
    check_eq("f3_cnt", 32'(bus.lq_count), 32'h0);

    // stall holds the queue and ignores ALU inputs
    set_alu(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hB6);
    set_ld(1'b1, 5'd15, 32'h15);
    step();
    set_ld(1'b1, 5'd16, 32'h16);
    step();
    set_ld(1'b0, 5'd0, 32'h0);
    bus.en = 1'b0;
    set_alu(1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stall_wr1", 32'(bus.reg_write), 32'h0);
      check_eq("stall_wr2", 32'(bus.reg_write2), 32'h0);
      check_eq("stall_cnt", 32'(bus.lq_count), 32'h2);
    end
    bus.en = 1'b1;
    set_alu(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check_eq("res_rd1", 32'(bus.regd), 32'd15);
    check_eq("res_d1", bus.write_data, 32'h15);
    check_eq("res_rd2", 32'(bus.regd2), 32'd16);
    check_eq("res_d2", bus.write_data2, 32'h16);
    step();

    // rd = 0 load is swallowed
    set_ld(1'b1, 5'd0, 32'hDEAD);
    step();
    set_ld(1'b0, 5'd0, 32'h0);
    check_eq("r0_cnt", 32'(bus.lq_count), 32'h0);
    check_eq("r0_wr1a", 32'(bus.reg_write), 32'h0);
    step();
    check_eq("r0_wr1b", 32'(bus.reg_write), 32'h0);
    check_eq("r0_wr2b", 32'(bus.reg_write2), 32'h0);

    // load latency into an empty queue
    set_ld(1'b1, 5'd3, 32'h33);
    step();
    set_ld(1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
    check_eq("lat_wr1", 32'(bus.reg_write), 32'h1);
    check_eq("lat_rd1", 32'(bus.regd), 32'd3);
    check_eq("lat_d1", bus.write_data, 32'h33);
    check_eq("lat_cnt", 32'(bus.lq_count), 32'h0);
    step();
    check_eq("lat_wr1b", 32'(bus.reg_write), 32'h0);
`else
    check_eq("lat_wr1", 32'(bus.reg_write), 32'h0);
    check_eq("lat_cnt", 32'(bus.lq_count), 32'h1);
    check_eq("lat_pend", bus.pending_mask, 32'h0000_0008);
    step();
    check_eq("lat_wr1b", 32'(bus.reg_write), 32'h1);
    check_eq("lat_rd1b", 32'(bus.regd), 32'd3);
    check_eq("lat_d1b", bus.write_data, 32'h33);
    check_eq("lat_pendb", bus.pending_mask, 32'h0000_0008);
`endif
    step();
    check_eq("lat_pend0", bus.pending_mask, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
